// File: rtl/dhs_obi_arbiter.sv
// Round-robin arbiter sharing one OBI master port between NUM_REQ requesters,
// with an in-order ID FIFO to route responses. Define DHS_OBI_ARB_FIXED_PRIO_EN for fixed priority.
module dhs_obi_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int OBI_ADDRW       = 32,
  parameter int OBI_DATAW       = 32,
  parameter int OBI_STRBW       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic [NUM_REQ-1:0]                  req_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  input  logic [NUM_REQ-1:0][OBI_ADDRW-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]                  we_i,
  input  logic [NUM_REQ-1:0][OBI_DATAW-1:0]   wdata_i,
  input  logic [NUM_REQ-1:0][OBI_STRBW-1:0]   be_i,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic [NUM_REQ-1:0][OBI_DATAW-1:0]   rdata_o,
  output logic                                m_req_o,
  input  logic                                m_gnt_i,
  output logic [OBI_ADDRW-1:0]                m_addr_o,
  output logic                                m_we_o,
  output logic [OBI_DATAW-1:0]                m_wdata_o,
  output logic [OBI_STRBW-1:0]                m_be_o,
  input  logic                                m_rvalid_i,
  input  logic [OBI_DATAW-1:0]                m_rdata_i,
  output logic                                err_o
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = PW + 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                            state_q;
  logic [IDW-1:0]                    sel_q;
  logic [MAX_OUTSTANDING-1:0][IDW-1:0] fifo_q;
  logic [PW-1:0]                     wptr_q, rptr_q;
  logic [CW-1:0]                     cnt_q;
  logic                              err_q;
`ifndef DHS_OBI_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]                    rr_q;
`endif

  logic                 full, hs, pop, spur, m_req, win_vld;
  logic [NUM_REQ-1:0]   elig;
  logic [IDW-1:0]       win, sel;

  // A full FIFO blocks grants even when a pop lands in the same cycle.
  assign full = (cnt_q == CW'(MAX_OUTSTANDING));
  assign elig = req_i & {NUM_REQ{~full}};

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
`ifdef DHS_OBI_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (elig[IDW'(i)]) begin
        win     = IDW'(i);
        win_vld = 1'b1;
      end
    end
`else
    // Scan from lowest priority upward so the last hit is the rr_q-nearest one.
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (elig[IDW'((int'(rr_q) + k) % NUM_REQ)]) begin
        win     = IDW'((int'(rr_q) + k) % NUM_REQ);
        win_vld = 1'b1;
      end
    end
`endif
  end

  assign sel   = (state_q == HOLD || !win_vld) ? sel_q : win;
  assign m_req = elig[sel] & ~arst_i;
  assign hs    = m_req & m_gnt_i;
  assign pop   = m_rvalid_i & (cnt_q != '0) & ~arst_i;
  assign spur  = m_rvalid_i & (cnt_q == '0);

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (hs)  gnt_o[sel] = 1'b1;
    if (pop) rvalid_o[fifo_q[rptr_q]] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rdata_o[i] = arst_i ? '0 : m_rdata_i;
    m_addr_o  = arst_i ? '0 : addr_i[sel];
    m_we_o    = arst_i ? 1'b0 : we_i[sel];
    m_wdata_o = arst_i ? '0 : wdata_i[sel];
    m_be_o    = arst_i ? '0 : be_i[sel];
  end

  assign m_req_o = m_req;
  assign err_o   = err_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      fifo_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifndef DHS_OBI_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (m_req) begin
          sel_q <= sel;
          if (!m_gnt_i) state_q <= HOLD;
        end
        HOLD: if (!req_i[sel_q]) begin
          // Requester withdrew before its grant: protocol violation.
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else if (m_gnt_i) begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (hs) begin
        fifo_q[wptr_q] <= sel;
        wptr_q         <= wptr_q + 1'b1;
`ifndef DHS_OBI_ARB_FIXED_PRIO_EN
        rr_q           <= (sel == IDW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
`endif
      end
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (spur) err_q  <= 1'b1;
      if (hs && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!hs && pop) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: tb/tb_dhs_obi_arbiter.sv
// Randomized + directed bench for dhs_obi_arbiter against a queue-based model.
module tb_dhs_obi_arbiter;
  localparam int N = 2, AW = 32, DW = 32, SW = 4, MAXO = 4;

  logic                 clk = 1'b0, arst;
  logic [N-1:0]         req, gnt, we, rvalid;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata, rdata;
  logic [N-1:0][SW-1:0] be;
  logic                 m_req, m_gnt, m_we, m_rvalid, err;
  logic [AW-1:0]        m_addr;
  logic [DW-1:0]        m_wdata, m_rdata;
  logic [SW-1:0]        m_be;

  dhs_obi_arbiter #(.NUM_REQ(N), .OBI_ADDRW(AW), .OBI_DATAW(DW), .OBI_STRBW(SW),
                    .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .arst_i(arst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .m_req_o(m_req),
    .m_gnt_i(m_gnt), .m_addr_o(m_addr), .m_we_o(m_we), .m_wdata_o(m_wdata), .m_be_o(m_be),
    .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .err_o(err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Model: outstanding requester IDs in issue order, rr pointer, locked index (-1 none), error flag.
  int q[$];
  int rr = 0, hold = -1;
  bit merr = 0;
  int n_push, n_rr, n_hold;
  bit n_pop, n_err, n_rst;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); rr = 0; hold = -1; merr = 0;
  endtask

  task automatic eval_cmp();
    int sel;
    bit emreq, full;
    logic [N-1:0] egnt, ervalid;
    n_push = -1; n_pop = 0; n_rr = rr; n_hold = hold; n_err = merr; n_rst = 0;
    if (arst) begin
      n_rst = 1;
      chk("rst_m_req", m_req, 0); chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0); chk("rst_err", err, 0);
      chk("rst_m_addr", m_addr, 0); chk("rst_rdata0", rdata[0], 0);
      return;
    end
    full = (q.size() >= MAXO);
    sel = -1;
    if (hold >= 0) sel = hold;
    else for (int k = 0; k < N; k++)
      if (sel < 0 && req[(rr + k) % N] && !full) sel = (rr + k) % N;
    emreq   = (sel >= 0) && req[sel] && !full;
    egnt    = '0;
    ervalid = '0;
    if (emreq && m_gnt) egnt[sel] = 1'b1;
    if (m_rvalid && q.size() > 0) ervalid[q[0]] = 1'b1;
    chk("m_req", m_req, emreq);
    chk("gnt", gnt, egnt);
    chk("rvalid", rvalid, ervalid);
    chk("err", err, merr);
    if (emreq) begin
      chk("m_addr", m_addr, addr[sel]);
      chk("m_we", m_we, we[sel]);
      chk("m_wdata", m_wdata, wdata[sel]);
      chk("m_be", m_be, be[sel]);
    end
    for (int i = 0; i < N; i++) chk("rdata", rdata[i], m_rdata);
    if (hold >= 0 && !req[hold]) begin n_err = 1; n_hold = -1; end
    else if (emreq && m_gnt) begin n_push = sel; n_rr = (sel + 1) % N; n_hold = -1; end
    else if (emreq) n_hold = sel;
    if (m_rvalid && q.size() == 0) n_err = 1;
    n_pop = m_rvalid && q.size() > 0;
  endtask

  task automatic commit();
    if (n_rst) begin model_reset(); return; end
    if (n_pop) void'(q.pop_front());
    if (n_push >= 0) q.push_back(n_push);
    rr = n_rr; hold = n_hold; merr = n_err;
  endtask

  task automatic settle(); #1; eval_cmp(); endtask
  task automatic tick(); @(posedge clk); commit(); @(negedge clk); endtask

  task automatic drive(input logic [N-1:0] r, input logic g, input logic rv, input logic [DW-1:0] rd);
    req = r; m_gnt = g; m_rvalid = rv; m_rdata = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  bit pend[N];

  initial begin
    arst = 1'b1;
    drive('0, 0, 0, '0);
    we = '0; wdata = '0; be = '0;
    addr[0] = 32'h1000_0000; addr[1] = 32'h4000_0010;
    model_reset();
    @(negedge clk); settle();
    @(posedge clk); commit(); @(negedge clk);
    arst = 1'b0;

    // reset state, nothing requested
    settle(); chk("idle_m_req", m_req, 0); chk("idle_err", err, 0); tick();

    // both request with continuous grant: 0,1,0,1
    drive(2'b11, 1, 0, '0);
    for (int i = 0; i < 4; i++) begin
      settle(); chk("alt_gnt", gnt, (i % 2) ? 2'b10 : 2'b01); tick();
    end
    // FIFO full: 5th request blocked, even while a pop happens
    settle(); chk("full_m_req", m_req, 0); chk("full_gnt", gnt, 0); tick();
    drive(2'b11, 1, 1, 32'hA5A5_0000);
    settle(); chk("resp0_rvalid", rvalid, 2'b01); chk("resp0_rdata", rdata[0], 32'hA5A5_0000);
    chk("pop_full_m_req", m_req, 0); tick();
    drive(2'b11, 1, 0, '0);
    settle(); chk("reen_gnt", gnt, 2'b01); tick();
    drive(2'b00, 0, 1, 32'h5A5A_0001);
    settle(); chk("resp1_rvalid", rvalid, 2'b10); chk("resp1_rdata", rdata[1], 32'h5A5A_0001); tick();
    settle(); chk("resp2_rvalid", rvalid, 2'b01); tick();
    // count 2 (oldest is requester 1): push+pop together
    drive(2'b01, 1, 1, 32'h1234);
    settle(); chk("pp_rvalid", rvalid, 2'b10); chk("pp_gnt", gnt, 2'b01); tick();
    drive(2'b01, 1, 0, '0);
    settle(); chk("pp_g3", gnt, 2'b01); tick();
    settle(); chk("pp_g4", gnt, 2'b01); tick();
    settle(); chk("pp_full", m_req, 0); tick();
    drive(2'b00, 0, 1, 32'h77);
    for (int i = 0; i < 4; i++) begin settle(); chk("drain", rvalid, 2'b01); tick(); end

    // selection lock: rr points at 0 after a grant to 1, then 1 is held
    drive(2'b10, 1, 0, '0); settle(); tick();
    drive(2'b10, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin settle(); chk("lock_addr", m_addr, 32'h4000_0010); tick(); end
    req = 2'b11;
    settle(); chk("lock_addr_r0", m_addr, 32'h4000_0010); chk("lock_gnt0", gnt, 0); tick();
    m_gnt = 1;
    settle(); chk("lock_gnt", gnt, 2'b10); tick();
    drive(2'b00, 0, 1, 32'h99);
    for (int i = 0; i < 2; i++) begin settle(); tick(); end

    // randomized, protocol-compliant traffic
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1; addr[i] = $urandom; we[i] = $urandom_range(1, 0);
          wdata[i] = $urandom; be[i] = SW'($urandom);
        end
        req[i] = pend[i];
      end
      m_gnt    = ($urandom_range(9, 0) < 7);
      m_rvalid = (q.size() > 0) && ($urandom_range(1, 0) == 1);
      m_rdata  = $urandom;
      settle();
      for (int i = 0; i < N; i++) if (gnt[i]) pend[i] = 0;
      tick();
    end

    // reset with 3 outstanding, rr left at 1
    drive(2'b00, 0, 1, '0);
    for (int i = 0; i < 8 && q.size() > 0; i++) begin settle(); tick(); end
    drive(2'b01, 1, 0, '0); settle(); tick();
    drive(2'b10, 1, 0, '0); settle(); tick();
    drive(2'b01, 1, 0, '0); settle(); tick();
    chk("pre_rst_outstanding", q.size(), 3);
    drive(2'b11, 1, 1, 32'hFFFF_FFFF);
    arst = 1'b1; model_reset();
    settle(); chk("mid_rst_gnt", gnt, 0); chk("mid_rst_rvalid", rvalid, 0); tick();
    arst = 1'b0;
    // response after reset is spurious: count was cleared
    drive(2'b00, 0, 1, 32'h55);
    settle(); chk("spur_rvalid", rvalid, 0); chk("spur_err_now", err, 0); tick();
    drive(2'b11, 1, 0, '0);
    settle(); chk("spur_err", err, 1); chk("rr_after_rst", gnt, 2'b01); tick();
    for (int i = 0; i < 3; i++) begin settle(); chk("err_sticky", err, 1); tick(); end
    arst = 1'b1; model_reset(); settle(); tick(); arst = 1'b0;
    drive(2'b00, 0, 0, '0);
    settle(); chk("err_cleared", err, 0); tick();

    // dropping req while held is a protocol error
    drive(2'b10, 0, 0, '0); settle(); tick();
    req = 2'b00;
    settle(); chk("drop_m_req", m_req, 0); tick();
    drive(2'b01, 1, 0, '0);
    settle(); chk("drop_err", err, 1); chk("drop_idle_gnt", gnt, 2'b01); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
